// File: rtl/regfile_pkg.sv
// Shared defaults, address-width helper and address type for the scoreboarded register file.
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    // Returns ceil(log2(n)) for n in 2..64.
    function automatic int calc_aw(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 7; i++) begin
            if ((1 << i) < n) w = i + 1;
        end
        return w;
    endfunction

    localparam int AW_DEFAULT = calc_aw(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0] reg_addr_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: issue-time reservations, writeback clears, reject logic and busy popcount.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS = NREGS_DEFAULT,
    localparam int AW    = calc_aw(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             reserve_enable,
    input  logic [AW-1:0]    reserve_addr,
    input  logic             write_enable,
    input  logic [AW-1:0]    write_addr,
    output logic [NREGS-1:0] busy,
    output logic [AW:0]      busy_count,
    output logic             reserve_reject
);

    logic [NREGS-1:0] busy_reg;
    logic [NREGS-1:0] busy_next;
    logic [AW:0]      count_reg;
    logic [AW:0]      count_next;
    logic             reserve_valid;
    logic             write_valid;
    logic             do_reserve;

    always_comb begin
        reserve_valid  = reserve_enable && (reserve_addr != '0);
        write_valid    = write_enable && (write_addr != '0);
        // A same-edge writeback to the busy register frees it, so the new reservation may proceed.
        reserve_reject = reserve_valid && busy_reg[reserve_addr]
                         && !(write_valid && (write_addr == reserve_addr));
        do_reserve     = reserve_valid && !reserve_reject;

        busy_next = busy_reg;
        if (write_valid) busy_next[write_addr] = 1'b0;
        if (do_reserve)  busy_next[reserve_addr] = 1'b1;
        busy_next[0] = 1'b0;

        count_next = '0;
        for (int i = 1; i < NREGS; i++) begin
            count_next = count_next + {{AW{1'b0}}, busy_next[i]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_reg  <= '0;
            count_reg <= '0;
        end else begin
            busy_reg  <= busy_next;
            count_reg <= count_next;
        end
    end

    assign busy       = busy_reg;
    assign busy_count = count_reg;

endmodule

// File: rtl/regfile_sb.sv
// Register file with x0 hardwired to zero, NRD combinational read ports and a busy scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to matching read ports.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEFAULT,
    parameter  int NREGS = NREGS_DEFAULT,
    parameter  int NRD   = 2,
    localparam int AW    = calc_aw(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NRD*AW-1:0] read_addr,
    output logic [NRD*XLEN-1:0] read_data,
    output logic [NRD-1:0]    read_busy,
    input  logic              write_enable,
    input  logic [AW-1:0]     write_addr,
    input  logic [XLEN-1:0]   write_data,
    input  logic              reserve_enable,
    input  logic [AW-1:0]     reserve_addr,
    output logic [AW:0]       busy_count,
    output logic              reserve_reject
);

    logic [XLEN-1:0]  regs_reg [NREGS];
    logic [NREGS-1:0] busy;

    regfile_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk            (clk),
        .reset_n        (reset_n),
        .reserve_enable (reserve_enable),
        .reserve_addr   (reserve_addr),
        .write_enable   (write_enable),
        .write_addr     (write_addr),
        .busy           (busy),
        .busy_count     (busy_count),
        .reserve_reject (reserve_reject)
    );

    // Whole-array clear on reset rules out block RAM; storage is flops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (write_enable && (write_addr != '0)) begin
            regs_reg[write_addr] <= write_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
            logic [AW-1:0] addr;
            logic          fwd;

            assign addr = read_addr[gi*AW +: AW];
`ifdef REGFILE_BYPASS_EN
            assign fwd = write_enable && (write_addr == addr) && (addr != '0);
`else
            assign fwd = 1'b0;
`endif
            assign read_data[gi*XLEN +: XLEN] = (addr == '0) ? '0 :
                                                fwd ? write_data : regs_reg[addr];
            // busy[0] is never set, so x0 always reads not-busy.
            assign read_busy[gi] = !fwd && busy[addr];
        end
    endgenerate

endmodule
